// File: rtl/clause_bin_sequencer.sv
// Moves one bin of clauses between the clause BRAM and the clause array.
// Load copies BRAM -> array; update copies array -> BRAM. Both use a two-stage issue/data pipeline.
module clause_bin_sequencer #(
    parameter int NUM_CLAUSES_A_BIN  = 8,
    parameter int WIDTH_CLAUSES      = 16,
    parameter int WIDTH_BIN_ID       = 10,
    parameter int ADDR_WIDTH_CLAUSES = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_load_i,
    input  logic                          start_update_i,
    input  logic [WIDTH_BIN_ID-1:0]       bin_id_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [NUM_CLAUSES_A_BIN-1:0]  wr_carray_o,
    output logic [NUM_CLAUSES_A_BIN-1:0]  rd_carray_o,
    output logic [WIDTH_CLAUSES-1:0]      clause_o,
    input  logic [WIDTH_CLAUSES-1:0]      clause_i,
    output logic                          ram_we_o,
    output logic [ADDR_WIDTH_CLAUSES-1:0] ram_addr_o,
    output logic [WIDTH_CLAUSES-1:0]      ram_din_o,
    input  logic [WIDTH_CLAUSES-1:0]      ram_dout_i
);

    localparam int CNT_W = $clog2(NUM_CLAUSES_A_BIN) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CLAUSES_A_BIN);
    localparam logic [NUM_CLAUSES_A_BIN-1:0] ONE = NUM_CLAUSES_A_BIN'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        UPDATE,
        DONE
    } state_t;

    state_t                        state, state_nxt;
    logic [CNT_W-1:0]              step, step_nxt, step_prev;
    logic [WIDTH_BIN_ID-1:0]       bin_q, bin_nxt;
    logic [ADDR_WIDTH_CLAUSES-1:0] base;
    logic [ADDR_WIDTH_CLAUSES-1:0] addr_q;
    logic [WIDTH_CLAUSES-1:0]      clause_q, din_q;
    logic                          vld_p0, vld_p1;

    // Truncating both operands first keeps the product modulo 2^ADDR_WIDTH_CLAUSES.
    assign base      = ADDR_WIDTH_CLAUSES'(bin_q) * ADDR_WIDTH_CLAUSES'(NUM_CLAUSES_A_BIN);
    assign step_prev = step - CNT_W'(1);
    assign vld_p0    = (step < LAST);
    assign vld_p1    = (step != '0);

    always_comb begin
        state_nxt   = state;
        step_nxt    = step;
        bin_nxt     = bin_q;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        wr_carray_o = '0;
        rd_carray_o = '0;
        ram_we_o    = 1'b0;
        clause_o    = clause_q;
        ram_din_o   = din_q;
        ram_addr_o  = addr_q;
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (start_load_i) begin
                    state_nxt = LOAD;
                    step_nxt  = '0;
                    bin_nxt   = bin_id_i;
                end else if (start_update_i) begin
                    state_nxt = UPDATE;
                    step_nxt  = '0;
                    bin_nxt   = bin_id_i;
                end
            end
            LOAD: begin
                // p0: present BRAM address; p1: BRAM data lands in the array one step behind
                if (vld_p0) ram_addr_o = base + ADDR_WIDTH_CLAUSES'(step);
                if (vld_p1) begin
                    wr_carray_o = ONE << step_prev;
                    clause_o    = ram_dout_i;
                end
                if (step == LAST) state_nxt = DONE;
                else              step_nxt  = step + CNT_W'(1);
            end
            UPDATE: begin
                // p0: select array entry; p1: its clause is written to BRAM one step behind
                if (vld_p0) rd_carray_o = ONE << step;
                if (vld_p1) begin
                    ram_we_o   = 1'b1;
                    ram_addr_o = base + ADDR_WIDTH_CLAUSES'(step_prev);
                    ram_din_o  = clause_i;
                end
                if (step == LAST) state_nxt = DONE;
                else              step_nxt  = step + CNT_W'(1);
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Hold registers keep address/data outputs stable between pipeline slots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            step     <= '0;
            bin_q    <= '0;
            addr_q   <= '0;
            clause_q <= '0;
            din_q    <= '0;
        end else begin
            state    <= state_nxt;
            step     <= step_nxt;
            bin_q    <= bin_nxt;
            addr_q   <= ram_addr_o;
            clause_q <= clause_o;
            din_q    <= ram_din_o;
        end
    end

endmodule

// File: tb/tb_clause_bin_sequencer.sv
// Bench for clause_bin_sequencer: BRAM and clause-array environment, timeline reference model,
// directed scenarios plus randomized operations.
module tb_clause_bin_sequencer;

    localparam int N  = 8;
    localparam int WC = 16;
    localparam int WB = 10;
    localparam int WA = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_load_i = 1'b0, start_update_i = 1'b0;
    logic [WB-1:0] bin_id_i = '0;
    logic          busy_o, done_o, ram_we_o;
    logic [N-1:0]  wr_carray_o, rd_carray_o;
    logic [WC-1:0] clause_o, clause_i, ram_din_o, ram_dout_i;
    logic [WA-1:0] ram_addr_o;

    always #5 clk = ~clk;

    clause_bin_sequencer #(
        .NUM_CLAUSES_A_BIN (N),
        .WIDTH_CLAUSES     (WC),
        .WIDTH_BIN_ID      (WB),
        .ADDR_WIDTH_CLAUSES(WA)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_load_i  (start_load_i),
        .start_update_i(start_update_i),
        .bin_id_i      (bin_id_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .wr_carray_o   (wr_carray_o),
        .rd_carray_o   (rd_carray_o),
        .clause_o      (clause_o),
        .clause_i      (clause_i),
        .ram_we_o      (ram_we_o),
        .ram_addr_o    (ram_addr_o),
        .ram_din_o     (ram_din_o),
        .ram_dout_i    (ram_dout_i)
    );

    // Environment: BRAM with one-cycle read latency, clause array with registered read.
    logic [WC-1:0] mem [1 << WA];
    logic [WC-1:0] carr [N];
    logic          pmem_we = 1'b0, pcar_we = 1'b0;
    logic [WA-1:0] pmem_addr = '0;
    logic [WC-1:0] pmem_data = '0, pcar_data = '0;
    int            pcar_idx = 0;

    always @(posedge clk) begin
        if (ram_we_o) mem[ram_addr_o] <= ram_din_o;
        else if (pmem_we) mem[pmem_addr] <= pmem_data;
        ram_dout_i <= mem[ram_addr_o];
        for (int k = 0; k < N; k++) begin
            if (wr_carray_o[k]) carr[k] <= clause_o;
            if (rd_carray_o[k]) clause_i <= carr[k];
        end
        if (pcar_we) carr[pcar_idx] <= pcar_data;
    end

    int checks = 0, failures = 0;
    int we_count = 0, done_count = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference model: operation phase t counts cycles since the accepting edge.
    logic [WC-1:0] gold_mem [1 << WA];
    logic [WC-1:0] gold_car [N];
    int            op = 0, t = 0;
    logic [WA-1:0] mbase = '0;
    logic [WA-1:0] e_addr = '0;
    logic [WC-1:0] e_clause = '0, e_din = '0;
    logic [N-1:0]  e_wr, e_rd;
    logic          e_we, e_busy, e_done;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                op = 0; e_addr = '0; e_clause = '0; e_din = '0;
            end else begin
                if (pmem_we) gold_mem[pmem_addr] = pmem_data;
                if (pcar_we) gold_car[pcar_idx] = pcar_data;
                if (op != 0) begin
                    t++;
                    if (t > N + 1) op = 0;
                end else if (start_load_i || start_update_i) begin
                    op    = start_load_i ? 1 : 2;
                    t     = 0;
                    mbase = WA'((int'(bin_id_i) * N) % (1 << WA));
                end
            end
            @(negedge clk);
            if (rst) begin
                op = 0; e_addr = '0; e_clause = '0; e_din = '0;
            end
            e_busy = (op != 0);
            e_done = (op != 0) && (t == N + 1);
            e_wr = '0; e_rd = '0; e_we = 1'b0;
            if (op == 1) begin
                if (t < N) e_addr = mbase + WA'(t);
                if (t >= 1 && t <= N) begin
                    e_wr        = N'(1) << (t - 1);
                    e_clause    = gold_mem[mbase + WA'(t - 1)];
                    gold_car[t - 1] = e_clause;
                end
            end else if (op == 2) begin
                if (t < N) e_rd = N'(1) << t;
                if (t >= 1 && t <= N) begin
                    e_we   = 1'b1;
                    e_addr = mbase + WA'(t - 1);
                    e_din  = gold_car[t - 1];
                    gold_mem[e_addr] = e_din;
                end
            end
            chk("busy", 32'(busy_o), 32'(e_busy));
            chk("done", 32'(done_o), 32'(e_done));
            chk("wr_carray", 32'(wr_carray_o), 32'(e_wr));
            chk("rd_carray", 32'(rd_carray_o), 32'(e_rd));
            chk("ram_we", 32'(ram_we_o), 32'(e_we));
            chk("ram_addr", 32'(ram_addr_o), 32'(e_addr));
            chk("clause_o", 32'(clause_o), 32'(e_clause));
            chk("ram_din", 32'(ram_din_o), 32'(e_din));
            if (ram_we_o) we_count++;
            if (done_o) done_count++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pre_mem(input logic [WA-1:0] a, input logic [WC-1:0] d);
        pmem_we = 1'b1; pmem_addr = a; pmem_data = d;
        step();
        pmem_we = 1'b0;
    endtask

    task automatic pre_car(input int k, input logic [WC-1:0] d);
        pcar_we = 1'b1; pcar_idx = k; pcar_data = d;
        step();
        pcar_we = 1'b0;
    endtask

    task automatic start(input logic ld, input logic up, input logic [WB-1:0] b);
        start_load_i = ld; start_update_i = up; bin_id_i = b;
        step();
        start_load_i = 1'b0; start_update_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) chk("idle_timeout", 32'(n), 32'd0);
    endtask

    int lat, busy_low, we0, d0;
    logic [WB-1:0] rb;
    logic [WA-1:0] ra;

    initial begin
        step(); step();
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_addr", 32'(ram_addr_o), 32'd0);
        rst = 1'b0;
        step();

        // Load bin 2 from BRAM[16..23]
        for (int k = 0; k < N; k++) pre_mem(WA'(16 + k), WC'(16'h1001 + k));
        start(1'b1, 1'b0, WB'(2));
        lat = -1; busy_low = 0;
        for (int i = 0; i < 20; i++) begin
            if (done_o) begin lat = i; break; end
            if (!busy_o) busy_low++;
            step();
        end
        chk("load_done_latency", 32'(lat), 32'd9);
        chk("load_busy_low", 32'(busy_low), 32'd0);
        wait_idle();
        for (int k = 0; k < N; k++) chk("load_carray", 32'(carr[k]), 32'h1001 + k);

        // Update bin 1 from the clause array
        for (int k = 0; k < N; k++) pre_car(k, WC'(16'h2000 + k));
        we0 = we_count;
        start(1'b0, 1'b1, WB'(1));
        wait_idle();
        chk("update_we_cycles", 32'(we_count - we0), 32'd8);
        for (int k = 0; k < N; k++) chk("update_mem", 32'(mem[8 + k]), 32'h2000 + k);

        // Both starts together: load wins
        we0 = we_count; d0 = done_count;
        start(1'b1, 1'b1, WB'(0));
        wait_idle();
        step();
        chk("both_we_cycles", 32'(we_count - we0), 32'd0);
        chk("both_done_pulses", 32'(done_count - d0), 32'd1);

        // Address wrap-around
        start(1'b1, 1'b0, WB'(63));
        chk("wrap63_first", 32'(ram_addr_o), 32'd504);
        repeat (7) step();
        chk("wrap63_last", 32'(ram_addr_o), 32'd511);
        wait_idle();
        start(1'b1, 1'b0, WB'(64));
        chk("wrap64_first", 32'(ram_addr_o), 32'd0);
        repeat (7) step();
        chk("wrap64_last", 32'(ram_addr_o), 32'd7);
        wait_idle();

        // Starts while busy are ignored
        d0 = done_count;
        start(1'b1, 1'b0, WB'(5));
        step();
        start(1'b0, 1'b1, WB'(9));
        start(1'b1, 1'b0, WB'(9));
        wait_idle();
        step();
        chk("busy_start_done_pulses", 32'(done_count - d0), 32'd1);
        chk("busy_start_bin", 32'(dut.bin_q), 32'd5);

        // Reset at load step 3
        d0 = done_count;
        start(1'b1, 1'b0, WB'(3));
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_wr", 32'(wr_carray_o), 32'd0);
        chk("rst_addr", 32'(ram_addr_o), 32'd0);
        chk("rst_clause", 32'(clause_o), 32'd0);
        step();
        rst = 1'b0;
        step(); step();
        chk("rst_no_done", 32'(done_count - d0), 32'd0);
        start(1'b1, 1'b0, WB'(3));
        wait_idle();
        step();
        chk("after_rst_done", 32'(done_count - d0), 32'd1);

        // Randomized operations
        for (int it = 0; it < 20; it++) begin
            rb = WB'($urandom_range(0, (1 << WB) - 1));
            for (int k = 0; k < N; k++) begin
                pre_car(k, WC'($urandom));
                pre_mem(WA'((int'(rb) * N + k) % (1 << WA)), WC'($urandom));
            end
            start(1'($urandom), 1'($urandom), rb);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 8)) step();
                start(1'($urandom), 1'($urandom), WB'($urandom));
            end
            wait_idle();
            repeat ($urandom_range(1, 3)) step();
            for (int k = 0; k < N; k++) begin
                ra = WA'((int'(rb) * N + k) % (1 << WA));
                chk("rand_carray", 32'(carr[k]), 32'(gold_car[k]));
                chk("rand_mem", 32'(mem[ra]), 32'(gold_mem[ra]));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
